// File: rtl/cmp_pkg.sv
// Shared compare definitions: relation encodings, FSM state encoding and the
// relation selector, reused by compare/sort blocks.
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_GE = 2'b00,
      CMP_GT = 2'b01,
      CMP_EQ = 2'b10,
      CMP_LT = 2'b11
   } cmp_op_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COMPARE = 1'b1
   } cmp_state_e;

   function automatic logic rel_result(cmp_op_e op, logic gt, logic eq, logic lt);
      logic r;
      unique case (op)
         CMP_GE:  r = gt | eq;
         CMP_GT:  r = gt;
         CMP_EQ:  r = eq;
         CMP_LT:  r = lt;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/iter_comparator_if.sv
// Start/done handshake and operand/outcome bundle of the iterative comparator.
interface iter_comparator_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             is_signed;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic             result;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (
      output start, a, b, is_signed, op,
      input  busy, done, result, gt, eq, lt
   );

   modport slave (
      input  start, a, b, is_signed, op,
      output busy, done, result, gt, eq, lt
   );
endinterface

// File: rtl/iter_comparator_chunk_cmp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   output logic             gt,
   output logic             lt
);
   assign gt = (x > y);
   assign lt = (x < y);
endmodule

// File: rtl/iter_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle MSB first,
// stopping on the first differing chunk.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | waiting for start; outcome registers hold the last result
//  ST_COMPARE | walking chunks from idx=NCHUNK-1 down to 0
module iter_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic             clk,
   input logic             rst,
   iter_comparator_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   cmp_state_e                   state_q, state_d;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d;
   logic [NCHUNK-1:0][CHUNK-1:0] b_q, b_d;
   cmp_op_e                      op_q, op_d;
   logic [IDXW-1:0]              idx_q, idx_d;
   logic                         gt_q, gt_d;
   logic                         eq_q, eq_d;
   logic                         lt_q, lt_d;
   logic                         result_q, result_d;
   logic                         done_q, done_d;

   logic [WIDTH-1:0] sign_mask;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             c_gt, c_lt;

   // Flipping the sign bit maps two's-complement order onto unsigned order,
   // so the chunk compare itself never needs to know about signedness.
   assign sign_mask = {bus.is_signed, {(WIDTH-1){1'b0}}};

   assign a_chunk = a_q[idx_q];
   assign b_chunk = b_q[idx_q];

   chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
      .x  (a_chunk),
      .y  (b_chunk),
      .gt (c_gt),
      .lt (c_lt)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      idx_d    = idx_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      result_d = result_q;
      done_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a ^ sign_mask;
               b_d     = bus.b ^ sign_mask;
               op_d    = cmp_op_e'(bus.op);
               idx_d   = IDXW'(NCHUNK - 1);
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (c_gt || c_lt) begin
               gt_d     = c_gt;
               eq_d     = 1'b0;
               lt_d     = c_lt;
               result_d = rel_result(op_q, c_gt, 1'b0, c_lt);
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else if (idx_q == '0) begin
               gt_d     = 1'b0;
               eq_d     = 1'b1;
               lt_d     = 1'b0;
               result_d = rel_result(op_q, 1'b0, 1'b1, 1'b0);
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               idx_d = idx_q - IDXW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= CMP_GE;
         idx_q    <= '0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         result_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = (state_q == ST_COMPARE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.gt     = gt_q;
   assign bus.eq     = eq_q;
   assign bus.lt     = lt_q;

endmodule

// File: tb/tb_iter_comparator.sv
// Directed and randomized checks of iter_comparator in 8-bit-chunk and
// single-chunk builds.
module tb_iter_comparator;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   iter_comparator_if #(.WIDTH(32)) bus8 ();
   iter_comparator_if #(.WIDTH(32)) bus32 ();

   iter_comparator #(.WIDTH(32), .CHUNK(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   iter_comparator #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int lat, output logic got);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         got = bus8.done;
      end
   endtask

   task automatic run8(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [1:0] op, input int exp_lat,
                       input logic egt, input logic eeq, input logic elt, input logic eres);
      int   lat;
      logic got;
      bus8.a = a; bus8.b = b; bus8.is_signed = sgn; bus8.op = op; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a = ~a; bus8.b = a; bus8.is_signed = ~sgn; bus8.op = ~op;
      chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      wait_done(lat, got);
      chk({tag, "_done"}, 32'(got), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_flags"}, {29'd0, bus8.gt, bus8.eq, bus8.lt}, {29'd0, egt, eeq, elt});
      chk({tag, "_res"}, 32'(bus8.result), 32'(eres));
      chk({tag, "_idle"}, 32'(bus8.busy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(bus8.done), 32'd0);
      chk({tag, "_hold"}, {28'd0, bus8.gt, bus8.eq, bus8.lt, bus8.result},
          {28'd0, egt, eeq, elt, eres});
   endtask

   initial begin
      int          lat;
      logic        got;
      logic        any_done;
      logic [31:0] ra, rb;
      logic        rs, egt, eeq, elt, eres;
      logic [1:0]  rop;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0; bus8.op = 2'b00;
      bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.is_signed = 1'b0; bus32.op = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {26'd0, bus8.busy, bus8.done, bus8.result, bus8.gt, bus8.eq, bus8.lt},
          32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run8("t1_ge", 32'h12345678, 32'h12345677, 1'b0, 2'b00, 4, 1'b1, 1'b0, 1'b0, 1'b1);
      run8("t2_ugt", 32'hFF000000, 32'h01000000, 1'b0, 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b1);
      run8("t2_sgt", 32'hFF000000, 32'h01000000, 1'b1, 2'b01, 1, 1'b0, 1'b0, 1'b1, 1'b0);
      run8("t3_eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b10, 4, 1'b0, 1'b1, 1'b0, 1'b1);
      run8("t3_lt", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b11, 4, 1'b0, 1'b1, 1'b0, 1'b0);
      run8("s_min", 32'h80000000, 32'h7FFFFFFF, 1'b1, 2'b11, 1, 1'b0, 1'b0, 1'b1, 1'b1);
      run8("s_neg", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 2'b00, 4, 1'b1, 1'b0, 1'b0, 1'b1);
      run8("u_mid", 32'h00AB0000, 32'h00AC0000, 1'b0, 2'b00, 2, 1'b0, 1'b0, 1'b1, 1'b0);

      // start while busy is ignored; start on the done cycle is accepted
      bus8.a = 32'h12345678; bus8.b = 32'h12345677; bus8.is_signed = 1'b0; bus8.op = 2'b00;
      bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      @(posedge clk); #1;
      bus8.a = 32'h00000000; bus8.b = 32'hFFFFFFFF; bus8.op = 2'b11; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      lat = 2; got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         got = bus8.done;
      end
      chk("t4_done", 32'(got), 32'd1);
      chk("t4_lat", 32'(lat), 32'd4);
      chk("t4_res", {28'd0, bus8.gt, bus8.eq, bus8.lt, bus8.result}, 32'b1001);
      bus8.a = 32'h00000001; bus8.b = 32'h00000002; bus8.op = 2'b11; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      chk("t4_b2b_busy", 32'(bus8.busy), 32'd1);
      wait_done(lat, got);
      chk("t4_b2b_done", 32'(got), 32'd1);
      chk("t4_b2b_lat", 32'(lat), 32'd4);
      chk("t4_b2b_res", {28'd0, bus8.gt, bus8.eq, bus8.lt, bus8.result}, 32'b0011);
      @(posedge clk); #1;

      // reset mid-compare aborts without a done pulse
      bus8.a = 32'h00000001; bus8.b = 32'h00000002; bus8.op = 2'b11; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_rst_outs", {26'd0, bus8.busy, bus8.done, bus8.result, bus8.gt, bus8.eq, bus8.lt},
          32'd0);
      any_done = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         any_done = any_done | bus8.done | bus8.busy;
      end
      chk("t5_no_done", 32'(any_done), 32'd0);

      // rst and start together: start dropped
      bus8.a = 32'h5; bus8.b = 32'h3; bus8.op = 2'b01; bus8.start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0; rst = 1'b0;
      chk("rst_start_busy", 32'(bus8.busy), 32'd0);
      @(posedge clk); #1;
      chk("rst_start_idle", {30'd0, bus8.busy, bus8.done}, 32'd0);
      run8("t5_after", 32'h00000005, 32'h00000003, 1'b0, 2'b01, 4, 1'b1, 1'b0, 1'b0, 1'b1);

      // single-chunk build against a behavioural reference
      for (int i = 0; i < 1000; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 7) == 0) rb = ra ^ 32'h80000000;
         rs  = 1'($urandom_range(0, 1));
         rop = 2'($urandom_range(0, 3));
         if (rs) begin
            egt = $signed(ra) > $signed(rb);
            elt = $signed(ra) < $signed(rb);
         end else begin
            egt = ra > rb;
            elt = ra < rb;
         end
         eeq = (ra == rb);
         case (rop)
            2'b00:   eres = egt | eeq;
            2'b01:   eres = egt;
            2'b10:   eres = eeq;
            default: eres = elt;
         endcase
         bus32.a = ra; bus32.b = rb; bus32.is_signed = rs; bus32.op = rop; bus32.start = 1'b1;
         @(posedge clk); #1;
         bus32.start = 1'b0;
         bus32.a = ~ra; bus32.op = ~rop; bus32.is_signed = ~rs;
         got = bus32.busy;
         @(posedge clk); #1;
         chk($sformatf("rand32_%0d", i),
             {26'd0, got, bus32.done, bus32.gt, bus32.eq, bus32.lt, bus32.result},
             {26'd0, 1'b1, 1'b1, egt, eeq, elt, eres});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
